// File: rtl/gear_button_conditioner.sv
// Synchronises, debounces and edge-detects the shift/brake buttons, then arbitrates them into
// stretched single-shot shift requests for the slow gearbox FSM. Optional macro: GEAR_AUTOREPEAT_EN.
module gear_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STRETCH_CYCLES  = 50_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_brake_raw,
    output logic shift_up,
    output logic shift_down,
    output logic brake,
    output logic busy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(STRETCH_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(STRETCH_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || STRETCH_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("gear_button_conditioner: cycle parameters must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DOWN} state_t;

    // Bit 0 = up, bit 1 = down, bit 2 = brake.
    logic [2:0]    raw_d;
    logic [2:0]    meta_q, sync_q, stable_q;
    logic [DW-1:0] deb_cnt_q [3];
    logic [1:0]    stable_dly_q, qual_q, fill_q;
    logic          up_evt_d, down_evt_d, start_up_d, start_down_d;
    logic          rpt_fire_up_d, rpt_fire_down_d;
    state_t        state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          shift_up_q, shift_down_q, busy_q;

    assign raw_d = {btn_brake_raw, btn_down_raw, btn_up_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
        end else begin
            meta_q <= raw_d;
            sync_q <= meta_q;
            for (int i = 0; i < 3; i++) begin
                if (sync_q[i] == stable_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_q[i]  <= sync_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A shift button only qualifies once it has been seen low after reset, so a button held
    // through reset must be released and pressed again before it can request a shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_dly_q <= '0;
            qual_q       <= '0;
            fill_q       <= '0;
        end else begin
            stable_dly_q <= stable_q[1:0];
            fill_q       <= {fill_q[0], 1'b1};
            qual_q       <= qual_q | ({2{fill_q[1]}} & ~sync_q[1:0]);
        end
    end

    assign up_evt_d     = stable_q[0] & ~stable_dly_q[0] & qual_q[0];
    assign down_evt_d   = stable_q[1] & ~stable_dly_q[1] & qual_q[1];
    assign start_up_d   = ((up_evt_d & ~down_evt_d) | rpt_fire_up_d) & ~stable_q[2];
    assign start_down_d = ((down_evt_d & ~up_evt_d) | rpt_fire_down_d) & ~stable_q[2];

`ifdef GEAR_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_cnt_q;
    logic          rpt_arm_q, rpt_dir_q;
    logic          rpt_held_d, hold_done_d, held_now_d;

    assign hold_done_d     = (state_q != IDLE) && (hold_cnt_q == HOLD_LAST);
    assign held_now_d      = (state_q == HOLD_DOWN) ? stable_q[1] : stable_q[0];
    assign rpt_held_d      = (rpt_dir_q ? stable_q[1] : stable_q[0]) & ~stable_q[2];
    assign rpt_fire_up_d   = rpt_arm_q & rpt_held_d & ~rpt_dir_q & (rpt_cnt_q == RPT_LAST);
    assign rpt_fire_down_d = rpt_arm_q & rpt_held_d &  rpt_dir_q & (rpt_cnt_q == RPT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_arm_q <= 1'b0;
            rpt_dir_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else if (hold_done_d && held_now_d && !stable_q[2]) begin
            rpt_arm_q <= 1'b1;
            rpt_dir_q <= (state_q == HOLD_DOWN);
            rpt_cnt_q <= '0;
        end else if (!rpt_arm_q || state_q != IDLE || !rpt_held_d || rpt_cnt_q == RPT_LAST) begin
            rpt_arm_q <= 1'b0;
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_q + 1'b1;
        end
    end
`else
    assign rpt_fire_up_d   = 1'b0;
    assign rpt_fire_down_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            shift_up_q   <= 1'b0;
            shift_down_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    hold_cnt_q <= '0;
                    if (start_up_d) begin
                        state_q    <= HOLD_UP;
                        shift_up_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (start_down_d) begin
                        state_q      <= HOLD_DOWN;
                        shift_down_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                HOLD_UP, HOLD_DOWN: begin
                    if (stable_q[2] || hold_cnt_q == HOLD_LAST) begin
                        state_q      <= IDLE;
                        hold_cnt_q   <= '0;
                        shift_up_q   <= 1'b0;
                        shift_down_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    hold_cnt_q   <= '0;
                    shift_up_q   <= 1'b0;
                    shift_down_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign shift_up   = shift_up_q;
    assign shift_down = shift_down_q;
    assign busy       = busy_q;
    assign brake      = stable_q[2];
endmodule

// File: tb/tb_gear_button_conditioner.sv
// Scoreboard bench for gear_button_conditioner with DEBOUNCE=4, STRETCH=8, REPEAT=16.
module tb_gear_button_conditioner;
    localparam int DEB = 4;
    localparam int STR = 8;
    localparam int RPT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up_raw = 1'b0, btn_down_raw = 1'b0, btn_brake_raw = 1'b0;
    logic shift_up, shift_down, brake, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int rise;
        int len;
    } req_t;
    req_t exp_q[$];

    gear_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .STRETCH_CYCLES (STR),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .btn_brake_raw(btn_brake_raw),
        .shift_up     (shift_up),
        .shift_down   (shift_down),
        .brake        (brake),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: measures each request (kind 0 = up, 1 = down) and pops the scoreboard on its fall.
    logic [1:0] mon_prev = 2'b00;
    int mon_rise [2];
    int mon_len  [2];
    always @(negedge clk) begin
        logic [1:0] cur;
        req_t e;
        cur = {shift_down, shift_up};
        if (reset) begin
            mon_prev = 2'b00;
        end else begin
            checks++;
            if (busy !== (shift_up | shift_down) || (shift_up & shift_down) !== 1'b0) begin
                errors++;
                $display("FAIL busy_mirror cyc=%0d busy=%b up=%b down=%b required busy=up|down, not both",
                         cyc, busy, shift_up, shift_down);
            end
            for (int k = 0; k < 2; k++) begin
                if (cur[k] && !mon_prev[k]) begin
                    mon_rise[k] = cyc;
                    mon_len[k]  = 0;
                end
                if (cur[k]) mon_len[k]++;
                if (!cur[k] && mon_prev[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_request kind=%0d rise=%0d len=%0d required none",
                                 k, mon_rise[k], mon_len[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind !== k || e.rise !== mon_rise[k] || e.len !== mon_len[k]) begin
                            errors++;
                            $display("FAIL request got kind=%0d rise=%0d len=%0d required kind=%0d rise=%0d len=%0d",
                                     k, mon_rise[k], mon_len[k], e.kind, e.rise, e.len);
                        end
                    end
                end
            end
            mon_prev = cur;
        end
    end

    // Returns on the falling clock edge at which cyc == target (target must lie in the future).
    task automatic at_neg(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        int r;
        btn_up_raw = 1'b1; btn_down_raw = 1'b1; btn_brake_raw = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({shift_up, shift_down, brake, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs up/down/brake/busy=%b required 0000", {shift_up, shift_down, brake, busy});
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        r = cyc;
        at_neg(r + 5);
        checks++;
        if (brake !== 1'b0) begin errors++; $display("FAIL brake_early got %b required 0", brake); end
        at_neg(r + 6);
        checks++;
        if (brake !== 1'b1) begin errors++; $display("FAIL brake_after_reset got %b required 1", brake); end
        at_neg(r + 12);
        checks++;
        if (shift_up !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_request up=%b busy=%b required 0 0", shift_up, busy);
        end
        btn_up_raw = 1'b0; btn_down_raw = 1'b0; btn_brake_raw = 1'b0;
        at_neg(cyc + 12);
        checks++;
        if (brake !== 1'b0) begin errors++; $display("FAIL brake_release got %b required 0", brake); end
    endtask

    task automatic test_bounce();
        int s;
        for (int i = 0; i < 10; i++) begin
            btn_up_raw = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn_up_raw = 1'b1;
        s = cyc;
        exp_q.push_back('{kind: 0, rise: s + 7, len: STR});
        at_neg(s + 6);
        checks++;
        if (shift_up !== 1'b0) begin errors++; $display("FAIL bounce_early up=%b required 0", shift_up); end
        at_neg(s + 7);
        checks++;
        if (shift_up !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bounce_rise up=%b busy=%b required 1 1", shift_up, busy);
        end
        at_neg(s + 15);
        checks++;
        if (shift_up !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce_fall up=%b busy=%b required 0 0", shift_up, busy);
        end
        btn_up_raw = 1'b0;
        at_neg(cyc + 12);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL bounce_missing outstanding=%0d required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        int s;
        btn_up_raw = 1'b1; btn_down_raw = 1'b1;
        s = cyc;
        at_neg(s + 7);
        checks++;
        if ({shift_up, shift_down, busy} !== 3'b000) begin
            errors++;
            $display("FAIL simul_a up/down/busy=%b required 000", {shift_up, shift_down, busy});
        end
        at_neg(s + 10);
        checks++;
        if ({shift_up, shift_down, busy} !== 3'b000) begin
            errors++;
            $display("FAIL simul_b up/down/busy=%b required 000", {shift_up, shift_down, busy});
        end
        btn_up_raw = 1'b0; btn_down_raw = 1'b0;
        at_neg(cyc + 12);
    endtask

    task automatic test_brake_priority();
        int s;
        btn_brake_raw = 1'b1;
        at_neg(cyc + 8);
        checks++;
        if (brake !== 1'b1) begin errors++; $display("FAIL brake_level got %b required 1", brake); end
        btn_down_raw = 1'b1;
        s = cyc;
        at_neg(s + 8);
        checks++;
        if (shift_down !== 1'b0 || brake !== 1'b1) begin
            errors++;
            $display("FAIL brake_blocks down=%b brake=%b required 0 1", shift_down, brake);
        end
        at_neg(s + 10);
        btn_down_raw = 1'b0;
        at_neg(s + 20);
        checks++;
        if (brake !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL brake_hold brake=%b busy=%b required 1 0", brake, busy);
        end
        btn_brake_raw = 1'b0;
        at_neg(cyc + 10);
    endtask

    task automatic test_brake_abort();
        int s;
        btn_up_raw = 1'b1;
        s = cyc;
        exp_q.push_back('{kind: 0, rise: s + 7, len: 3});
        at_neg(s + 3);
        btn_brake_raw = 1'b1;
        at_neg(s + 8);
        checks++;
        if (shift_up !== 1'b1 || brake !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre up=%b brake=%b required 1 0", shift_up, brake);
        end
        at_neg(s + 9);
        checks++;
        if (shift_up !== 1'b1 || brake !== 1'b1) begin
            errors++;
            $display("FAIL abort_brake up=%b brake=%b required 1 1", shift_up, brake);
        end
        at_neg(s + 10);
        checks++;
        if (shift_up !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop up=%b busy=%b required 0 0", shift_up, busy);
        end
        btn_up_raw = 1'b0;
        at_neg(cyc + 12);
        btn_brake_raw = 1'b0;
        at_neg(cyc + 12);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL abort_missing outstanding=%0d required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_press_during_hold();
        int s;
        btn_up_raw = 1'b1;
        s = cyc;
        exp_q.push_back('{kind: 0, rise: s + 7, len: STR});
        at_neg(s + 2);
        btn_down_raw = 1'b1;
        at_neg(s + 10);
        btn_up_raw = 1'b0; btn_down_raw = 1'b0;
        at_neg(s + 30);
        checks++;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL during_hold outstanding=%0d busy=%b required 0 0", exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_hold();
        int s;
        btn_up_raw = 1'b1;
        s = cyc;
        at_neg(s + 9);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (shift_up !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async up=%b busy=%b required 0 0", shift_up, busy);
        end
        at_neg(cyc + 3);
        reset = 1'b0;
        at_neg(cyc + 20);
        checks++;
        if (shift_up !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_no_rearm up=%b busy=%b required 0 0", shift_up, busy);
        end
        btn_up_raw = 1'b0;
        at_neg(cyc + 12);
        btn_up_raw = 1'b1;
        s = cyc;
        exp_q.push_back('{kind: 0, rise: s + 7, len: STR});
        at_neg(s + 12);
        btn_up_raw = 1'b0;
        at_neg(s + 30);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL rearm_missing outstanding=%0d required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_long_hold();
        int s;
        btn_up_raw = 1'b1;
        s = cyc;
        exp_q.push_back('{kind: 0, rise: s + 7, len: STR});
`ifdef GEAR_AUTOREPEAT_EN
        exp_q.push_back('{kind: 0, rise: s + 31, len: STR});
        exp_q.push_back('{kind: 0, rise: s + 55, len: STR});
`endif
        at_neg(s + 23);
        checks++;
        if (shift_up !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_gap up=%b busy=%b required 0 0", shift_up, busy);
        end
        at_neg(s + 60);
        btn_up_raw = 1'b0;
        at_neg(s + 80);
        checks++;
        if (exp_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_missing outstanding=%0d busy=%b required 0 0", exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bounce();
        test_simultaneous();
        test_brake_priority();
        test_brake_abort();
        test_press_during_hold();
        test_reset_mid_hold();
        test_long_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
